dac_scan_sequencer: RTL and testbench
=====================================

DAC_SCAN_SEQUENCER -- requirements
Module: dac_scan_sequencer

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 4096, is the maximum Clk cycles to wait for DacLoadDone after each DacLoadStart.
REQ-002 Clk  input  1  system clock; all logic is on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ScanStart  input  1  one-cycle pulse; starts a scan; honoured only in IDLE.
REQ-005 ScanAbort  input  1  level; requests scan termination.
REQ-006 StartCode, StopCode, StepSize  input  12 each  DAC1 scan range and increment.
REQ-007 FixedDac2Code  input  12  DAC2 value held constant for the whole scan.
REQ-008 SettleCycles  input  16  wait after each DAC load before StepReady.
REQ-009 StepAck  input  1  downstream measurement finished for the current code.
REQ-010 DacLoadDone  input  1  one-cycle done pulse from the TLV5618 DAC controller.
REQ-011 Dac1Data, Dac2Data  output  12 each  codes presented to the DAC controller.
REQ-012 LoadDacSelect  output  2  01 = DAC1 only, 11 = both DACs.
REQ-013 DacLoadStart  output  1  one-cycle load request to the DAC controller.
REQ-014 StepReady  output  1  high while the current code is settled and awaiting StepAck.
REQ-015 CurrentCode  output  12  DAC1 code in use.
REQ-016 ScanBusy, ScanDone, ScanError  output  1 each  status; ScanDone and ScanError are one-cycle pulses.

Function
REQ-017 States SHALL be IDLE, LOAD, WAIT_LOAD, SETTLE, STEP_READY, NEXT, DONE; ScanBusy is high in every state except IDLE.
REQ-018 In IDLE, ScanStart SHALL latch StartCode, StopCode, StepSize, FixedDac2Code and SettleCycles; later input changes do not affect the running scan.
REQ-019 If StepSize==0 or StartCode>StopCode at ScanStart, the block SHALL pulse ScanError for one cycle the next cycle and remain in IDLE.
REQ-020 On a valid start: CurrentCode=Dac1Data=StartCode, Dac2Data=FixedDac2Code, LoadDacSelect=11, and a one-cycle DacLoadStart on the cycle after ScanStart, then WAIT_LOAD.
REQ-021 DacLoadStart SHALL be high for exactly one cycle per load; Dac1Data, Dac2Data and LoadDacSelect stay stable from that cycle until DacLoadDone.
REQ-022 WAIT_LOAD: DacLoadDone SHALL move to SETTLE; if LOAD_TIMEOUT cycles pass without it, pulse ScanError and go to IDLE.
REQ-023 SETTLE SHALL count SettleCycles cycles and then enter STEP_READY; SettleCycles==0 goes to STEP_READY on the next cycle.
REQ-024 STEP_READY: StepReady is held high until StepAck is sampled high; StepReady clears the following cycle and the FSM enters NEXT.
REQ-025 NEXT SHALL form the 13-bit sum CurrentCode+StepSize; if sum>StopCode go to DONE, else CurrentCode=sum, LoadDacSelect=01, pulse DacLoadStart, go to WAIT_LOAD.
REQ-026 The 13-bit compare SHALL prevent 4095 wrap-around: a code is never issued above StopCode or below a previous code.
REQ-027 DONE SHALL pulse ScanDone for one cycle and return to IDLE; CurrentCode keeps the last issued code.
REQ-028 ScanAbort in SETTLE or STEP_READY SHALL go to IDLE the next cycle with StepReady low and no ScanDone.
REQ-029 ScanAbort in WAIT_LOAD SHALL be deferred until DacLoadDone or timeout so no SPI transfer is cut short; the FSM then goes to IDLE.
REQ-030 ScanAbort in LOAD or NEXT SHALL complete any DacLoadStart already issued and then be handled as in WAIT_LOAD.
REQ-031 If StepAck and ScanAbort are both high in STEP_READY, abort SHALL win.
REQ-032 ScanStart while ScanBusy is high SHALL be ignored.

Reset
REQ-033 While reset_n is low, all outputs SHALL be 0 and the FSM SHALL be IDLE; reset mid-scan drops DacLoadStart and StepReady at once, with no ScanDone or ScanError.
REQ-034 After reset release, the first valid ScanStart SHALL behave exactly as in REQ-020.

Verification
REQ-035 Start=100, Stop=130, Step=10, Settle=5, DAC model returns done 40 cycles after start, auto-ack -> codes 100(sel 11),110,120,130(sel 01); 4 StepReady; one ScanDone.
REQ-036 Start=4090, Stop=4095, Step=8 -> single code 4090, then ScanDone; no wrapped code issued.
REQ-037 Step=0, or Start=200 with Stop=100 -> ScanError one-cycle pulse; DacLoadStart never asserted.
REQ-038 DAC model never returns DacLoadDone -> ScanError exactly LOAD_TIMEOUT cycles after DacLoadStart; FSM in IDLE.
REQ-039 ScanAbort asserted during WAIT_LOAD and during STEP_READY -> first: IDLE only after DacLoadDone; second: IDLE next cycle; no ScanDone in either.
REQ-040 reset_n pulsed low during SETTLE with Settle=0 on the following run -> all outputs 0 during reset; the new run reaches StepReady one cycle after DacLoadDone.

Source files
------------

// File: rtl/dac_scan_sequencer.sv
// Steps DAC1 from StartCode to StopCode with DAC2 held fixed. Each step is a load, a settle wait and a StepReady/StepAck handshake.
// Every load request is a one-cycle DacLoadStart, and an abort never cuts a DAC transfer short.
module dac_scan_sequencer #(
    parameter int LOAD_TIMEOUT = 4096
) (
    input  logic        Clk,
    input  logic        reset_n,
    input  logic        ScanStart,
    input  logic        ScanAbort,
    input  logic [11:0] StartCode,
    input  logic [11:0] StopCode,
    input  logic [11:0] StepSize,
    input  logic [11:0] FixedDac2Code,
    input  logic [15:0] SettleCycles,
    input  logic        StepAck,
    input  logic        DacLoadDone,
    output logic [11:0] Dac1Data,
    output logic [11:0] Dac2Data,
    output logic [1:0]  LoadDacSelect,
    output logic        DacLoadStart,
    output logic        StepReady,
    output logic [11:0] CurrentCode,
    output logic        ScanBusy,
    output logic        ScanDone,
    output logic        ScanError
);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_LOAD, SETTLE, STEP_READY, NEXT, DONE
    } state_t;

    state_t      state, stateNext;
    logic [11:0] curCode, stopReg, stepReg, dac2Reg;
    logic [15:0] settleReg, settleCnt;
    logic [TW-1:0] timer;
    logic [1:0]  loadSel;
    logic        abortPending, scanErrorR;
    logic        startInvalid, timeoutHit, sumOver;
    logic [12:0] nextSum;

    assign startInvalid = (StepSize == 12'd0) || (StartCode > StopCode);
    assign timeoutHit   = (timer == TW'(LOAD_TIMEOUT - 1));
    // 13-bit sum so a step past 4095 reads as "beyond StopCode" instead of wrapping
    assign nextSum      = {1'b0, curCode} + {1'b0, stepReg};
    assign sumOver      = nextSum > {1'b0, stopReg};

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (ScanStart && !startInvalid) stateNext = LOAD;
            LOAD:       stateNext = WAIT_LOAD;
            WAIT_LOAD: begin
                if (DacLoadDone) begin
                    if (abortPending || ScanAbort) stateNext = IDLE;
                    else if (settleReg == 16'd0)   stateNext = STEP_READY;
                    else                           stateNext = SETTLE;
                end else if (timeoutHit) begin
                    stateNext = IDLE;
                end
            end
            SETTLE: begin
                if (ScanAbort)                    stateNext = IDLE;
                else if (settleCnt == settleReg)  stateNext = STEP_READY;
            end
            STEP_READY: begin
                if (ScanAbort)     stateNext = IDLE;
                else if (StepAck)  stateNext = NEXT;
            end
            NEXT: begin
                if (ScanAbort)     stateNext = IDLE;
                else if (sumOver)  stateNext = DONE;
                else               stateNext = LOAD;
            end
            DONE:       stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            curCode      <= '0;
            stopReg      <= '0;
            stepReg      <= '0;
            dac2Reg      <= '0;
            settleReg    <= '0;
            settleCnt    <= '0;
            timer        <= '0;
            loadSel      <= '0;
            abortPending <= 1'b0;
            scanErrorR   <= 1'b0;
        end else begin
            scanErrorR <= 1'b0;
            case (state)
                IDLE: begin
                    if (ScanStart) begin
                        if (startInvalid) begin
                            scanErrorR <= 1'b1;
                        end else begin
                            curCode   <= StartCode;
                            stopReg   <= StopCode;
                            stepReg   <= StepSize;
                            dac2Reg   <= FixedDac2Code;
                            settleReg <= SettleCycles;
                            loadSel   <= 2'b11;
                        end
                    end
                end
                LOAD: begin
                    timer        <= TW'(1);
                    abortPending <= ScanAbort;
                end
                WAIT_LOAD: begin
                    timer     <= timer + TW'(1);
                    settleCnt <= 16'd1;
                    if (ScanAbort) abortPending <= 1'b1;
                    if (!DacLoadDone && timeoutHit) scanErrorR <= 1'b1;
                end
                SETTLE: settleCnt <= settleCnt + 16'd1;
                NEXT: begin
                    if (!ScanAbort && !sumOver) begin
                        curCode <= nextSum[11:0];
                        loadSel <= 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Dac1Data      = curCode;
    assign Dac2Data      = dac2Reg;
    assign CurrentCode   = curCode;
    assign LoadDacSelect = loadSel;
    assign DacLoadStart  = (state == LOAD);
    assign StepReady     = (state == STEP_READY);
    assign ScanBusy      = (state != IDLE);
    assign ScanDone      = (state == DONE);
    assign ScanError     = scanErrorR;

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Directed bench for dac_scan_sequencer: expected loads are queued at ScanStart and popped on each DacLoadStart.
module tb_dac_scan_sequencer;
    logic        Clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ScanStart = 1'b0, ScanAbort = 1'b0, StepAck = 1'b0, DacLoadDone = 1'b0;
    logic [11:0] StartCode = '0, StopCode = '0, StepSize = '0, FixedDac2Code = '0;
    logic [15:0] SettleCycles = '0;
    logic [11:0] Dac1Data, Dac2Data, CurrentCode;
    logic [1:0]  LoadDacSelect;
    logic        DacLoadStart, StepReady, ScanBusy, ScanDone, ScanError;

    dac_scan_sequencer dut (
        .Clk(Clk), .reset_n(reset_n), .ScanStart(ScanStart), .ScanAbort(ScanAbort),
        .StartCode(StartCode), .StopCode(StopCode), .StepSize(StepSize),
        .FixedDac2Code(FixedDac2Code), .SettleCycles(SettleCycles), .StepAck(StepAck),
        .DacLoadDone(DacLoadDone), .Dac1Data(Dac1Data), .Dac2Data(Dac2Data),
        .LoadDacSelect(LoadDacSelect), .DacLoadStart(DacLoadStart), .StepReady(StepReady),
        .CurrentCode(CurrentCode), .ScanBusy(ScanBusy), .ScanDone(ScanDone), .ScanError(ScanError)
    );

    typedef struct {
        logic [11:0] d1;
        logic [11:0] d2;
        logic [1:0]  sel;
    } exp_t;

    exp_t expQ[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int nLoad = 0, nDone = 0, nReady = 0;
    int lastLoadCyc = 0, doneCyc = 0, readyCyc = 0;
    int dacDelay = 40;
    bit autoAck = 1'b1;

    initial forever #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Load monitor / scoreboard consumer
    initial begin
        exp_t e;
        logic prevReady = 1'b0, prevLoad = 1'b0, prevDone = 1'b0;
        forever begin
            @(negedge Clk);
            if (reset_n) begin
                if (DacLoadStart) begin
                    nLoad++;
                    lastLoadCyc = cyc;
                    chk("load_pulse_width", {31'd0, prevLoad}, 32'd0);
                    if (expQ.size() == 0) begin
                        chk("unexpected_load", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        chk("dac1_code", {20'd0, Dac1Data}, {20'd0, e.d1});
                        chk("dac2_code", {20'd0, Dac2Data}, {20'd0, e.d2});
                        chk("load_select", {30'd0, LoadDacSelect}, {30'd0, e.sel});
                    end
                end
                if (ScanDone) begin
                    nDone++;
                    chk("done_pulse_width", {31'd0, prevDone}, 32'd0);
                end
                if (StepReady && !prevReady) begin
                    nReady++;
                    readyCyc = cyc;
                end
                prevReady = StepReady;
                prevLoad  = DacLoadStart;
                prevDone  = ScanDone;
            end else begin
                prevReady = 1'b0;
                prevLoad  = 1'b0;
                prevDone  = 1'b0;
            end
        end
    end

    // DAC controller model: one-cycle done dacDelay cycles after a load, never if dacDelay==0
    initial forever begin
        @(negedge Clk);
        if (reset_n && DacLoadStart && dacDelay > 0) begin
            for (int i = 1; i < dacDelay; i++) begin
                @(negedge Clk);
                if (!reset_n) break;
            end
            if (reset_n) begin
                DacLoadDone = 1'b1;
                doneCyc = cyc;
                @(negedge Clk);
                DacLoadDone = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge Clk);
        if (autoAck) StepAck = StepReady;
    end

    task automatic startScan(input int s, input int p, input int st, input int settle,
                             input int d2, input int maxPush);
        int c = s;
        int n = 0;
        logic [1:0] sel = 2'b11;
        StartCode = 12'(s); StopCode = 12'(p); StepSize = 12'(st);
        SettleCycles = 16'(settle); FixedDac2Code = 12'(d2);
        if (st != 0 && s <= p) begin
            while (c <= p && n < maxPush) begin
                expQ.push_back('{d1: 12'(c), d2: 12'(d2), sel: sel});
                c += st;
                n++;
                sel = 2'b01;
            end
        end
        ScanStart = 1'b1;
        @(negedge Clk);
        ScanStart = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        @(negedge Clk);
        while (ScanBusy && n < budget) begin
            @(negedge Clk);
            n++;
        end
        chk("idle_within_budget", {31'd0, ScanBusy}, 32'd0);
    endtask

    initial begin
        int b0, b1, b2, n;

        // Reset state
        @(negedge Clk);
        chk("rst_dac1", {20'd0, Dac1Data}, 0);
        chk("rst_dac2", {20'd0, Dac2Data}, 0);
        chk("rst_sel", {30'd0, LoadDacSelect}, 0);
        chk("rst_loadstart", {31'd0, DacLoadStart}, 0);
        chk("rst_stepready", {31'd0, StepReady}, 0);
        chk("rst_curcode", {20'd0, CurrentCode}, 0);
        chk("rst_busy", {31'd0, ScanBusy}, 0);
        chk("rst_done", {31'd0, ScanDone}, 0);
        chk("rst_error", {31'd0, ScanError}, 0);
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Basic scan 100..130 step 10; mid-scan input changes and a second ScanStart must be ignored
        b0 = nReady; b1 = nDone;
        startScan(100, 130, 10, 5, 2000, 16);
        repeat (10) @(negedge Clk);
        StartCode = 12'd7; StopCode = 12'd4000; StepSize = 12'd1;
        FixedDac2Code = 12'd0; SettleCycles = 16'd99;
        ScanStart = 1'b1;
        @(negedge Clk);
        ScanStart = 1'b0;
        waitIdle(2000);
        chk("a_stepready_count", nReady - b0, 4);
        chk("a_done_count", nDone - b1, 1);
        chk("a_queue_drained", expQ.size(), 0);
        chk("a_last_code", {20'd0, CurrentCode}, 130);

        // Top of range: 4090 + 8 must not wrap
        b0 = nLoad; b1 = nDone;
        startScan(4090, 4095, 8, 3, 55, 16);
        waitIdle(500);
        chk("b_load_count", nLoad - b0, 1);
        chk("b_done_count", nDone - b1, 1);
        chk("b_last_code", {20'd0, CurrentCode}, 4090);
        chk("b_queue_drained", expQ.size(), 0);

        // Invalid starts
        b0 = nLoad;
        startScan(50, 60, 0, 1, 1, 16);
        chk("c_step0_error", {31'd0, ScanError}, 1);
        chk("c_step0_busy", {31'd0, ScanBusy}, 0);
        @(negedge Clk);
        chk("c_step0_error_pulse", {31'd0, ScanError}, 0);
        startScan(200, 100, 5, 1, 1, 16);
        chk("c_order_error", {31'd0, ScanError}, 1);
        @(negedge Clk);
        chk("c_order_error_pulse", {31'd0, ScanError}, 0);
        repeat (3) @(negedge Clk);
        chk("c_no_load", nLoad - b0, 0);

        // Load timeout
        dacDelay = 0;
        startScan(10, 20, 5, 1, 9, 1);
        n = 0;
        while (!ScanError && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        chk("t_error_seen", {31'd0, ScanError}, 1);
        chk("t_error_latency", cyc - lastLoadCyc, 4096);
        chk("t_idle_at_error", {31'd0, ScanBusy}, 0);
        chk("t_queue_drained", expQ.size(), 0);
        dacDelay = 40;

        // Abort during WAIT_LOAD is deferred until DacLoadDone
        b0 = nDone; b1 = nReady;
        startScan(1000, 2000, 100, 5, 3, 1);
        n = 0;
        while (!DacLoadStart && n < 10) begin
            @(negedge Clk);
            n++;
        end
        repeat (2) @(negedge Clk);
        ScanAbort = 1'b1;
        repeat (15) @(negedge Clk);
        chk("w_still_busy", {31'd0, ScanBusy}, 1);
        waitIdle(100);
        chk("w_idle_after_done", cyc, doneCyc + 1);
        ScanAbort = 1'b0;
        chk("w_no_done", nDone - b0, 0);
        chk("w_no_stepready", nReady - b1, 0);

        // Abort beats StepAck in STEP_READY
        autoAck = 1'b0;
        StepAck = 1'b0;
        dacDelay = 10;
        b0 = nDone;
        startScan(300, 400, 50, 2, 4, 1);
        n = 0;
        while (!StepReady && n < 100) begin
            @(negedge Clk);
            n++;
        end
        chk("s_stepready_seen", {31'd0, StepReady}, 1);
        ScanAbort = 1'b1;
        StepAck = 1'b1;
        @(negedge Clk);
        chk("s_idle_next", {31'd0, ScanBusy}, 0);
        chk("s_stepready_low", {31'd0, StepReady}, 0);
        ScanAbort = 1'b0;
        StepAck = 1'b0;
        repeat (3) @(negedge Clk);
        chk("s_no_done", nDone - b0, 0);
        chk("s_queue_drained", expQ.size(), 0);
        autoAck = 1'b1;

        // Reset during SETTLE, then a settle-0 run
        b1 = nDone;
        startScan(600, 700, 10, 20, 6, 1);
        n = 0;
        while (!DacLoadDone && n < 100) begin
            @(negedge Clk);
            n++;
        end
        repeat (3) @(negedge Clk);
        reset_n = 1'b0;
        #1;
        chk("r_busy_in_reset", {31'd0, ScanBusy}, 0);
        @(negedge Clk);
        chk("r_dac1_in_reset", {20'd0, Dac1Data}, 0);
        chk("r_curcode_in_reset", {20'd0, CurrentCode}, 0);
        chk("r_sel_in_reset", {30'd0, LoadDacSelect}, 0);
        chk("r_stepready_in_reset", {31'd0, StepReady}, 0);
        chk("r_done_in_reset", {31'd0, ScanDone}, 0);
        chk("r_error_in_reset", {31'd0, ScanError}, 0);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
        chk("r_no_done", nDone - b1, 0);
        b2 = nDone;
        startScan(500, 500, 1, 0, 8, 16);
        waitIdle(200);
        chk("r_ready_after_done", readyCyc, doneCyc + 1);
        chk("r_done_count", nDone - b2, 1);
        chk("r_queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
